imem_loader: RTL and testbench

Boot-time program loader upstream of the RISC-V core. It accepts a framed byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instructions, and writes them sequentially into instruction memory from word address 0. It verifies an XOR checksum and raises `core_run`, which drives the core's `enable`, only after a clean load. The core never fetches from a partially written program.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_word_assembler.sv | 50 +++++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : TypesPkg
// Brief    : Shared types for the instruction-memory boot loader.
// Revision : 1.0
// ============================================================================
package TypesPkg;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_t;

    localparam int C_WORD_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : word_assembler
// Brief    : Packs bytes little-endian into 32-bit words, one-cycle word_done.
// Revision : 1.0
// ============================================================================
module word_assembler
    import TypesPkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic [31:0] word_out
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    // The 4th byte bypasses the shift register so the word is complete
    // in the same cycle it is accepted.
    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        word_done = 1'b0;
        word_out  = {byte_in, shift_q};
        if (clear) begin
            cnt_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_valid) begin
            cnt_d     = cnt_q + 2'd1;
            shift_d   = {byte_in, shift_q[23:8]};
            word_done = (cnt_q == 2'(C_WORD_BYTES - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Framed byte-stream boot loader with XOR check; gates core_run.
// Revision : 1.0
// ============================================================================
module imem_loader
    import TypesPkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_run,
    output logic              load_err
);

    localparam logic [31:0]       C_MAX_WORDS = 32'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] C_ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};

    loader_state_t     state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [7:0]        xor_q, xor_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              accept;
    logic              asm_done;
    logic [31:0]       asm_word;
    logic [15:0]       len_full;
    logic              last_word;

    assign in_ready   = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                        (state_q == ST_DATA)   || (state_q == ST_CHK);
    assign core_run   = (state_q == ST_DONE);
    assign load_err   = (state_q == ST_ERROR);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

    // A restart drops any byte offered in the same cycle.
    assign accept    = in_valid && in_ready && !restart;
    assign len_full  = {in_data, len_q[7:0]};
    assign last_word = ((32'(word_cnt_q) + 32'd1) == 32'(len_q));

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_valid (accept && (state_q == ST_DATA)),
        .byte_in    (in_data),
        .word_done  (asm_done),
        .word_out   (asm_word)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        xor_d      = xor_q;
        we_d       = asm_done;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        if (asm_done) begin
            addr_d  = word_cnt_q;
            wdata_d = asm_word;
        end

        if (restart) begin
            state_d    = ST_LEN_LO;
            len_d      = 16'd0;
            word_cnt_d = '0;
            xor_d      = 8'd0;
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_LEN_LO;
                ST_LEN_LO: begin
                    if (accept) begin
                        len_d[7:0] = in_data;
                        xor_d      = xor_q ^ in_data;
                        state_d    = ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len_d  = len_full;
                        xor_d  = xor_q ^ in_data;
                        if (32'(len_full) > C_MAX_WORDS) begin
                            state_d = ST_ERROR;
                        end else if (len_full == 16'd0) begin
                            state_d = ST_CHK;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        xor_d = xor_q ^ in_data;
                    end
                    if (asm_done) begin
                        word_cnt_d = word_cnt_q + C_ONE;
                        if (last_word) begin
                            state_d = ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (accept) begin
                        state_d = (in_data == xor_q) ? ST_DONE : ST_ERROR;
                    end
                end
                ST_DONE:  state_d = ST_DONE;
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            len_q      <= 16'd0;
            word_cnt_q <= '0;
            xor_q      <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            xor_q      <= xor_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for imem_loader.
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              restart;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_run;
    logic              load_err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_run   (core_run),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Write log captured mid-cycle
    int          wr_n = 0;
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic        run_at_we = 1'b0;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = 32'(imem_addr);
                wr_data[wr_n] = imem_wdata;
            end
            if (core_run === 1'b1) run_at_we = 1'b1;
            wr_n = wr_n + 1;
        end
    end

    logic [7:0] fb [0:15];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] frame_xor(input int n);
        logic [7:0] x = 8'd0;
        for (int i = 0; i < n; i++) x = x ^ fb[i];
        return x;
    endfunction

    // Called at posedge+1; leaves in_valid high for back-to-back streaming.
    task automatic send_byte(input logic [7:0] b);
        int   waited = 0;
        logic rdy;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!rdy && waited < 20);
        if (!rdy) check("accept_timeout", 32'(rdy), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) send_byte(fb[i]);
        in_valid = 1'b0;
    endtask

    task automatic pulse_restart;
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    int base;
    int gaps [0:3] = '{2, 0, 3, 1};

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        restart  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),   32'd0);
        check("rst_we",        32'(imem_we),    32'd0);
        check("rst_addr",      32'(imem_addr),  32'd0);
        check("rst_wdata",     imem_wdata,      32'd0);
        check("rst_core_run",  32'(core_run),   32'd0);
        check("rst_load_err",  32'(load_err),   32'd0);
        reset = 1'b1;
        check("boot_not_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("len_lo_ready", 32'(in_ready), 32'd1);

        // Two-word frame, good checksum, full rate
        fb[0] = 8'h02; fb[1] = 8'h00;
        fb[2] = 8'h13; fb[3] = 8'h00; fb[4] = 8'h10; fb[5] = 8'h00;
        fb[6] = 8'h93; fb[7] = 8'h00; fb[8] = 8'h20; fb[9] = 8'h00;
        fb[10] = frame_xor(10);
        base = wr_n;
        for (int i = 0; i < 10; i++) send_byte(fb[i]);
        check("good_run_before_chk", 32'(core_run), 32'd0);
        check("good_chk_ready",      32'(in_ready), 32'd1);
        send_byte(fb[10]);
        in_valid = 1'b0;
        check("good_core_run", 32'(core_run), 32'd1);
        check("good_load_err", 32'(load_err), 32'd0);
        check("good_done_not_ready", 32'(in_ready), 32'd0);
        check("good_wr_count", 32'(wr_n - base), 32'd2);
        check("good_wr0_addr", wr_addr[base],     32'd0);
        check("good_wr0_data", wr_data[base],     32'h0010_0013);
        check("good_wr1_addr", wr_addr[base + 1], 32'd1);
        check("good_wr1_data", wr_data[base + 1], 32'h0020_0093);
        check("good_run_after_we", 32'(run_at_we), 32'd0);

        pulse_restart();
        check("restart_ready",    32'(in_ready), 32'd1);
        check("restart_core_run", 32'(core_run), 32'd0);

        // Same frame with a corrupted checksum
        fb[10] = frame_xor(10) ^ 8'h33;
        base = wr_n;
        send_frame(11);
        check("bad_load_err", 32'(load_err), 32'd1);
        check("bad_core_run", 32'(core_run), 32'd0);
        check("bad_ready",    32'(in_ready), 32'd0);
        check("bad_wr_count", 32'(wr_n - base), 32'd2);

        // Oversized length
        pulse_restart();
        check("restart_clears_err", 32'(load_err), 32'd0);
        fb[0] = 8'h01; fb[1] = 8'h01;
        base = wr_n;
        send_frame(2);
        check("big_load_err", 32'(load_err), 32'd1);
        check("big_ready",    32'(in_ready), 32'd0);
        idle(3);
        check("big_no_write", 32'(wr_n - base), 32'd0);

        // Empty program
        pulse_restart();
        fb[0] = 8'h00; fb[1] = 8'h00; fb[2] = 8'h00;
        base = wr_n;
        send_frame(3);
        check("empty_core_run", 32'(core_run), 32'd1);
        check("empty_no_write", 32'(wr_n - base), 32'd0);
        pulse_restart();
        check("empty_restart_run",   32'(core_run), 32'd0);
        check("empty_restart_ready", 32'(in_ready), 32'd1);

        // One word with valid gaps
        fb[0] = 8'h01; fb[1] = 8'h00;
        fb[2] = 8'hEF; fb[3] = 8'hBE; fb[4] = 8'hAD; fb[5] = 8'hDE;
        fb[6] = frame_xor(6);
        base = wr_n;
        send_byte(fb[0]); idle(2);
        send_byte(fb[1]); idle(1);
        for (int i = 0; i < 4; i++) begin
            send_byte(fb[2 + i]);
            if (i < 3) idle(gaps[i]);
        end
        check("gap_we",    32'(imem_we),   32'd1);
        check("gap_addr",  32'(imem_addr), 32'd0);
        check("gap_wdata", imem_wdata,     32'hDEAD_BEEF);
        idle(1);
        check("gap_we_one_cycle", 32'(imem_we), 32'd0);
        check("gap_wdata_hold",   imem_wdata,   32'hDEAD_BEEF);
        idle(2);
        send_byte(fb[6]);
        in_valid = 1'b0;
        check("gap_core_run", 32'(core_run), 32'd1);
        check("gap_wr_count", 32'(wr_n - base), 32'd1);

        // Maximum length accepted; restart drops the 4th byte of a word
        pulse_restart();
        fb[0] = 8'h00; fb[1] = 8'h01;
        send_frame(2);
        check("max_len_ok",    32'(load_err), 32'd0);
        check("max_len_ready", 32'(in_ready), 32'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        base = wr_n;
        in_data = 8'h44;
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart  = 1'b0;
        in_valid = 1'b0;
        check("drop_no_we", 32'(imem_we), 32'd0);
        check("drop_ready", 32'(in_ready), 32'd1);
        fb[0] = 8'h01; fb[1] = 8'h00;
        fb[2] = 8'hAA; fb[3] = 8'hBB; fb[4] = 8'hCC; fb[5] = 8'hDD;
        fb[6] = frame_xor(6);
        send_frame(7);
        check("after_drop_count", 32'(wr_n - base), 32'd1);
        check("after_drop_addr",  wr_addr[base], 32'd0);
        check("after_drop_data",  wr_data[base], 32'hDDCC_BBAA);
        check("after_drop_run",   32'(core_run), 32'd1);

        // Reset mid-load
        pulse_restart();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(in_ready),  32'd0);
        check("mid_rst_we",    32'(imem_we),   32'd0);
        check("mid_rst_addr",  32'(imem_addr), 32'd0);
        check("mid_rst_wdata", imem_wdata,     32'd0);
        check("mid_rst_run",   32'(core_run),  32'd0);
        check("mid_rst_err",   32'(load_err),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        fb[0] = 8'h02; fb[1] = 8'h00;
        fb[2] = 8'h78; fb[3] = 8'h56; fb[4] = 8'h34; fb[5] = 8'h12;
        fb[6] = 8'hF0; fb[7] = 8'hDE; fb[8] = 8'hBC; fb[9] = 8'h9A;
        fb[10] = frame_xor(10);
        base = wr_n;
        send_frame(11);
        check("post_rst_count", 32'(wr_n - base), 32'd2);
        check("post_rst_addr0", wr_addr[base],     32'd0);
        check("post_rst_data0", wr_data[base],     32'h1234_5678);
        check("post_rst_addr1", wr_addr[base + 1], 32'd1);
        check("post_rst_data1", wr_data[base + 1], 32'h9ABC_DEF0);
        check("post_rst_run",   32'(core_run), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
